// File: rtl/fpga_config_loader_if.sv
// rtl/fpga_config_loader_if.sv - configuration bitstream beat stream (data/valid/ready)
interface fpga_config_loader_if #(
  parameter int IN_W = 32
) ();
  logic [IN_W-1:0] cfg_data;
  logic            cfg_valid;
  logic            cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/fpga_config_loader.sv
// rtl/fpga_config_loader.sv - assembles stream beats into rows and writes the fabric config
module fpga_config_loader #(
  parameter int WORD_W     = 320,
  parameter int N_WORDS    = 172,
  parameter int IN_W       = 32,
  parameter int SETTLE_CYC = 10,
  parameter int RDY_DLY    = 10
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  fpga_config_loader_if.slave  cfg,
  output logic [WORD_W-1:0]    configs_in,
  output logic [N_WORDS-1:0]   configs_en,
  output logic                 ff_en,
  output logic                 rdy,
  output logic                 busy
);
  localparam int BEATS = WORD_W / IN_W;
  localparam int K_W   = $clog2(N_WORDS + 1);
  localparam int B_W   = $clog2(BEATS + 1);
  localparam int C_MAX = (SETTLE_CYC > RDY_DLY) ? SETTLE_CYC : RDY_DLY;
  localparam int C_W   = $clog2(C_MAX + 1);

  localparam logic [K_W-1:0]     LAST_ROW    = K_W'(N_WORDS - 1);
  localparam logic [B_W-1:0]     LAST_BEAT   = B_W'(BEATS - 1);
  localparam logic [C_W-1:0]     SETTLE_LAST = C_W'(SETTLE_CYC - 1);
  localparam logic [C_W-1:0]     RDY_LAST    = C_W'(RDY_DLY - 1);
  localparam logic [N_WORDS-1:0] EN_ONE      = N_WORDS'(1);

  typedef enum logic [2:0] {
    IDLE,
    ASSEMBLE,
    WRITE,
    HOLD,
    SETTLE,
    RUN_WAIT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [B_W-1:0]    b_q, b_d;
  logic [C_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0] configs_in_q, configs_in_d;

  // State, counters and assembled word; reset drops any partial row.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      configs_in_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      configs_in_q <= configs_in_d;
    end
  end

  // Next-state: beats land in the word only in ASSEMBLE, so the word is frozen through WRITE/HOLD.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    configs_in_d = configs_in_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ASSEMBLE;
          k_d     = '0;
          b_d     = '0;
        end
      end
      ASSEMBLE: begin
        if (cfg.cfg_valid) begin
          configs_in_d[b_q*IN_W +: IN_W] = cfg.cfg_data;
          b_d = b_q + 1'b1;
          if (b_q == LAST_BEAT) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        state_d = HOLD;
      end
      HOLD: begin
        k_d = k_q + 1'b1;
        if (k_q == LAST_ROW) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else begin
          state_d = ASSEMBLE;
          b_d     = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = RUN_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN_WAIT: begin
        if (cnt_q == RDY_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state so reset clears them without waiting for a clock.
  always_comb begin
    cfg.cfg_ready = (state_q == ASSEMBLE);
    configs_en    = (state_q == WRITE) ? (EN_ONE << k_q) : '0;
    configs_in    = configs_in_q;
    ff_en         = (state_q == RUN_WAIT) || (state_q == DONE);
    rdy           = (state_q == DONE);
    busy          = (state_q != IDLE) && (state_q != DONE);
  end
endmodule

// File: tb/tb_fpga_config_loader.sv
// tb/tb_fpga_config_loader.sv - directed bench for fpga_config_loader
module tb_fpga_config_loader;
  localparam int WORD_W  = 320;
  localparam int N_WORDS = 172;
  localparam int IN_W    = 32;
  localparam int BEATS   = 10;

  logic               clock = 1'b0;
  logic               rst;
  logic               start;
  logic [WORD_W-1:0]  configs_in;
  logic [N_WORDS-1:0] configs_en;
  logic               ff_en;
  logic               rdy;
  logic               busy;

  fpga_config_loader_if #(.IN_W(IN_W)) cfg ();

  fpga_config_loader #(
    .WORD_W(WORD_W), .N_WORDS(N_WORDS), .IN_W(IN_W), .SETTLE_CYC(10), .RDY_DLY(10)
  ) dut (
    .clock(clock),
    .rst(rst),
    .start(start),
    .cfg(cfg),
    .configs_in(configs_in),
    .configs_en(configs_en),
    .ff_en(ff_en),
    .rdy(rdy),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int src_row, src_beat, gap_row, gap_beat, gap_left, wr_exp;
  int write_cyc [N_WORDS];
  int ff_cyc, rdy_cyc;
  logic prev_xfer, prev_ff, prev_rdy;
  logic [WORD_W-1:0] prev_in, row0_word;

  function automatic logic [IN_W-1:0] beat_val(input int r, input int j);
    return IN_W'(r * 256 + j);
  endfunction

  function automatic logic [WORD_W-1:0] exp_word(input int r);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int j = 0; j < BEATS; j++) w[j*IN_W +: IN_W] = beat_val(r, j);
    return w;
  endfunction

  task automatic init_model();
    src_row = 0; src_beat = 0;
    gap_row = -1; gap_beat = 0; gap_left = 0;
    wr_exp = 0; ff_cyc = -1; rdy_cyc = -1;
    prev_xfer = 1'b0; prev_ff = 1'b0; prev_rdy = 1'b0;
    prev_in = '0; row0_word = '0;
    for (int i = 0; i < N_WORDS; i++) write_cyc[i] = -1;
  endtask

  // One clock: observe outputs at the falling edge, then drive the stream for the next rising edge.
  task automatic tick();
    logic [N_WORDS-1:0] one_hot;
    @(negedge clock);
    cyc++;
    checks++;
    assert ($onehot0(configs_en)) else begin
      errors++;
      $display("FAIL en_onehot cyc=%0d got=%h", cyc, configs_en);
    end
    if (!rst) begin
      checks++;
      if (configs_in !== '0 || configs_en !== '0 || cfg.cfg_ready !== 1'b0 ||
          ff_en !== 1'b0 || rdy !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d en=%h rdy_in=%b ff=%b rdy=%b busy=%b want all 0",
                 cyc, configs_en, cfg.cfg_ready, ff_en, rdy, busy);
      end
    end else if (!prev_xfer) begin
      checks++;
      if (configs_in !== prev_in) begin
        errors++;
        $display("FAIL in_stable cyc=%0d got=%h want=%h", cyc, configs_in, prev_in);
      end
    end
    if (configs_en !== '0) begin
      one_hot = '0;
      if (wr_exp < N_WORDS) one_hot[wr_exp] = 1'b1;
      checks++;
      if (configs_en !== one_hot) begin
        errors++;
        $display("FAIL en_row cyc=%0d got=%h want=%h", cyc, configs_en, one_hot);
      end
      checks++;
      if (configs_in !== exp_word(wr_exp)) begin
        errors++;
        $display("FAIL row_data row=%0d got=%h want=%h", wr_exp, configs_in, exp_word(wr_exp));
      end
      if (wr_exp == 0) row0_word = configs_in;
      if (wr_exp < N_WORDS) write_cyc[wr_exp] = cyc;
      wr_exp++;
    end
    if (ff_en && !prev_ff && ff_cyc < 0) ff_cyc = cyc;
    if (rdy && !prev_rdy && rdy_cyc < 0) rdy_cyc = cyc;
    prev_ff = ff_en;
    prev_rdy = rdy;
    prev_in = configs_in;
    cfg.cfg_valid = 1'b0;
    if (src_row < N_WORDS) begin
      if (src_row == gap_row && src_beat == gap_beat && gap_left > 0) gap_left--;
      else cfg.cfg_valid = 1'b1;
      cfg.cfg_data = beat_val(src_row, src_beat);
    end
    prev_xfer = cfg.cfg_valid && cfg.cfg_ready;
    if (prev_xfer) begin
      src_beat++;
      if (src_beat == BEATS) begin
        src_beat = 0;
        src_row++;
      end
    end
  endtask

  task automatic pulse_start(output int c0);
    start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    cfg.cfg_valid = 1'b0; cfg.cfg_data = '0;
    init_model();
    repeat (2) tick();
    checks++;
    if (configs_in !== '0 || configs_en !== '0) begin
      errors++; $display("FAIL reset_data in=%h en=%h want 0", configs_in, configs_en);
    end
    checks++;
    if ({cfg.cfg_ready, ff_en, rdy, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b want=0000", {cfg.cfg_ready, ff_en, rdy, busy});
    end
    rst = 1'b1;
    repeat (5) tick();
    checks++;
    if (cfg.cfg_ready !== 1'b0 || busy !== 1'b0 || src_beat !== 0) begin
      errors++; $display("FAIL idle_no_start ready=%b busy=%b beats=%0d want 0", cfg.cfg_ready, busy, src_beat);
    end
  endtask

  task automatic test_full_load();
    int c0;
    init_model();
    pulse_start(c0);
    for (int i = 0; i < 2200 && rdy_cyc < 0; i++) begin
      tick();
      if (cyc == c0 + 2064) begin
        checks++;
        if (busy !== 1'b1 || ff_en !== 1'b0 || cfg.cfg_ready !== 1'b0 || configs_en !== '0) begin
          errors++; $display("FAIL settle_state busy=%b ff=%b ready=%b want 1 0 0", busy, ff_en, cfg.cfg_ready);
        end
      end
    end
    checks++;
    if (wr_exp != N_WORDS) begin errors++; $display("FAIL row_count got=%0d want=%0d", wr_exp, N_WORDS); end
    checks++;
    if (write_cyc[0] != c0 + 10) begin errors++; $display("FAIL row0_time got=%0d want=%0d", write_cyc[0], c0 + 10); end
    checks++;
    if (write_cyc[171] != c0 + 2062) begin errors++; $display("FAIL row171_time got=%0d want=%0d", write_cyc[171], c0 + 2062); end
    checks++;
    if (ff_cyc != c0 + 2074) begin errors++; $display("FAIL ff_en_time got=%0d want=%0d", ff_cyc, c0 + 2074); end
    checks++;
    if (rdy_cyc != c0 + 2084) begin errors++; $display("FAIL rdy_time got=%0d want=%0d", rdy_cyc, c0 + 2084); end
    checks++;
    if (row0_word[31:0] !== 32'd0 || row0_word[319:288] !== 32'd9) begin
      errors++; $display("FAIL row0_slices lo=%h hi=%h want 0 9", row0_word[31:0], row0_word[319:288]);
    end
    checks++;
    if ({ff_en, rdy, busy, cfg.cfg_ready} !== 4'b1100) begin
      errors++; $display("FAIL done_outputs got=%b want=1100", {ff_en, rdy, busy, cfg.cfg_ready});
    end
  endtask

  task automatic test_start_in_done();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    checks++;
    if ({ff_en, rdy, busy, cfg.cfg_ready} !== 4'b1100 || wr_exp != N_WORDS) begin
      errors++; $display("FAIL done_persist got=%b rows=%0d want=1100 rows=%0d",
                         {ff_en, rdy, busy, cfg.cfg_ready}, wr_exp, N_WORDS);
    end
  endtask

  task automatic test_stall_and_start();
    int c0;
    do_reset();
    init_model();
    gap_row = 2; gap_beat = 4; gap_left = 5;
    pulse_start(c0);
    while (cyc < c0 + 15) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2200 && rdy_cyc < 0; i++) tick();
    checks++;
    if (write_cyc[1] != c0 + 22) begin errors++; $display("FAIL stall_row1 got=%0d want=%0d", write_cyc[1], c0 + 22); end
    checks++;
    if (write_cyc[2] != c0 + 39) begin errors++; $display("FAIL stall_row2 got=%0d want=%0d", write_cyc[2], c0 + 39); end
    checks++;
    if (write_cyc[3] != c0 + 51) begin errors++; $display("FAIL stall_row3 got=%0d want=%0d", write_cyc[3], c0 + 51); end
    checks++;
    if (write_cyc[171] != c0 + 2067) begin errors++; $display("FAIL stall_row171 got=%0d want=%0d", write_cyc[171], c0 + 2067); end
    checks++;
    if (ff_cyc != c0 + 2079 || rdy_cyc != c0 + 2089) begin
      errors++; $display("FAIL stall_ff_rdy got=%0d,%0d want=%0d,%0d", ff_cyc, rdy_cyc, c0 + 2079, c0 + 2089);
    end
    checks++;
    if (wr_exp != N_WORDS || gap_left != 0) begin
      errors++; $display("FAIL stall_rows got=%0d gap=%0d want=%0d 0", wr_exp, gap_left, N_WORDS);
    end
  endtask

  task automatic test_reset_midload();
    int c0;
    do_reset();
    init_model();
    pulse_start(c0);
    for (int i = 0; i < 1000 && !(src_row == 50 && src_beat == 5); i++) tick();
    checks++;
    if (cfg.cfg_ready !== 1'b1 || busy !== 1'b1 || wr_exp != 50) begin
      errors++; $display("FAIL row50_assemble ready=%b busy=%b rows=%0d want 1 1 50", cfg.cfg_ready, busy, wr_exp);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (configs_in !== '0 || configs_en !== '0 || {cfg.cfg_ready, ff_en, rdy, busy} !== 4'b0000) begin
      errors++; $display("FAIL async_reset in=%h ctrl=%b want 0", configs_in, {cfg.cfg_ready, ff_en, rdy, busy});
    end
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (cfg.cfg_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL no_auto_restart ready=%b busy=%b want 0 0", cfg.cfg_ready, busy);
    end
    init_model();
    pulse_start(c0);
    for (int i = 0; i < 100 && wr_exp < 3; i++) tick();
    checks++;
    if (write_cyc[0] != c0 + 10 || wr_exp != 3) begin
      errors++; $display("FAIL reload_row0 got=%0d rows=%0d want=%0d 3", write_cyc[0], wr_exp, c0 + 10);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_start_in_done();
    test_stall_and_start();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpga_config_loader.md
FPGA_CONFIG_LOADER -- requirements
Module: fpga_config_loader

Interface
REQ-001 Parameter WORD_W, 320, width of one fabric configuration word (configs_in).
REQ-002 Parameter N_WORDS, 172, number of configuration rows (width of configs_en).
REQ-003 Parameter IN_W, 32, stream beat width; WORD_W SHALL be an integer multiple of IN_W (BEATS = WORD_W/IN_W = 10).
REQ-004 Parameter SETTLE_CYC, 10, idle cycles between the last row write and ff_en assertion.
REQ-005 Parameter RDY_DLY, 10, cycles from ff_en assertion to rdy assertion.
REQ-006 clock  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-009 cfg_data  input  IN_W  bitstream beat.
REQ-010 cfg_valid  input  1  cfg_data valid.
REQ-011 cfg_ready  output  1  loader accepts a beat; a beat transfers when cfg_valid and cfg_ready are both high on a rising edge.
REQ-012 configs_in  output  WORD_W  assembled configuration word to the fabric.
REQ-013 configs_en  output  N_WORDS  one-hot row write enable to the fabric.
REQ-014 ff_en  output  1  fabric flip-flop enable, asserted after configuration completes.
REQ-015 rdy  output  1  fabric configured and running.
REQ-016 busy  output  1  high in every state except IDLE and DONE.

Function
REQ-017 The FSM SHALL have states IDLE, ASSEMBLE, WRITE, HOLD, SETTLE, RUN_WAIT and DONE.
REQ-018 IDLE: cfg_ready=0, configs_en=0; start=1 -> ASSEMBLE with row counter k=0 and beat counter b=0.
REQ-019 ASSEMBLE: cfg_ready=1; each accepted beat b is written to configs_in[IN_W*b +: IN_W] and increments b; cfg_valid=0 stalls with no state change.
REQ-020 The accepted beat with b=BEATS-1 SHALL move the FSM to WRITE on the same edge; no further beat is accepted until the next ASSEMBLE.
REQ-021 WRITE: exactly one cycle; configs_en = 1<<k; cfg_ready=0.
REQ-022 HOLD: exactly one cycle; configs_en=0; configs_in unchanged from WRITE; then k=k+1; if the new k < N_WORDS -> ASSEMBLE with b=0, else -> SETTLE.
REQ-023 configs_in SHALL change only on accepted beats and SHALL be stable throughout WRITE and HOLD.
REQ-024 SETTLE: counts SETTLE_CYC cycles with all enables 0, then -> RUN_WAIT with ff_en=1.
REQ-025 RUN_WAIT: ff_en=1; after RDY_DLY cycles -> DONE with rdy=1.
REQ-026 DONE: ff_en=1, rdy=1, busy=0, cfg_ready=0; start is ignored; only reset leaves DONE.
REQ-027 start asserted in any state other than IDLE SHALL be ignored.
REQ-028 Minimum time per row SHALL be BEATS+2 = 12 cycles; a full load with no stalls SHALL take N_WORDS*12 = 2064 cycles from the first ASSEMBLE cycle to the first SETTLE cycle.
REQ-029 Counters k and b SHALL be sized for N_WORDS and BEATS respectively and SHALL never wrap during a load.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, k=0, b=0, configs_in=0, configs_en=0, cfg_ready=0, ff_en=0, rdy=0, busy=0, regardless of the current state.
REQ-031 A reset during a load SHALL discard the partial word; a new load SHALL begin only on a fresh start after rst returns high.

Verification
REQ-032 Full load, cfg_valid held high, beat j = j -> configs_en bit k pulses exactly once per row; row 0 configs_in[31:0]=0 and [319:288]=9; ff_en rises 10 cycles after the last HOLD; rdy rises 10 cycles after ff_en.
REQ-033 cfg_valid deasserted for 5 cycles after beat 3 of row 2 -> no state change during the gap; the row 2 WRITE occurs 5 cycles later than in REQ-032; data is unchanged.
REQ-034 start pulsed during ASSEMBLE and again in DONE -> no effect; k continues and DONE persists.
REQ-035 rst=0 while in row 50 ASSEMBLE -> all outputs are 0 asynchronously; a following start reloads from row 0 and the next configs_en pulse is bit 0.
REQ-036 Row 171 HOLD -> the next state is SETTLE; configs_en never shows bit 172 or any multi-hot value.
REQ-037 configs_en SHALL be checked every cycle by an assertion as zero or one-hot, with configs_in stable throughout WRITE and HOLD.
